// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: arbiter state encoding and default stream widths.
package axis_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   localparam int AXIS_DW  = 8;
   localparam int AXIS_IDW = 3;

endpackage

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first active request after last_grant, wrapping modulo N.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [IW-1:0] grant,
   output logic          any_req
);

   // Offsets are scanned in increasing distance from last_grant so the most recent winner ranks lowest.
   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      for (int k = 1; k <= N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (!any_req && req[j] && (j == ((int'(last_grant) + k) % N))) begin
               any_req = 1'b1;
               grant   = IW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter sharing one registered AXI-Stream output between N_IN inputs.
module axis_rr_arbiter
   import axis_pkg::*;
#(
   parameter int N_IN = 2,
   parameter int DW   = AXIS_DW,
   parameter int IDW  = AXIS_IDW
) (
   input  logic               ACLK,
   input  logic               ARESETn,
   input  logic [N_IN*DW-1:0] s_tdata,
   input  logic [N_IN-1:0]    s_tvalid,
   input  logic [N_IN-1:0]    s_tlast,
   output logic [N_IN-1:0]    s_tready,
   output logic [DW-1:0]      m_tdata,
   output logic               m_tvalid,
   output logic               m_tlast,
   input  logic               m_tready,
   output logic [IDW-1:0]     grant_id,
   output logic               busy
);

   arb_state_e     state;
   arb_state_e     state_nxt;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] pick_idx;
   logic           any_req;
   logic           sel_valid;
   logic           sel_last;
   logic [DW-1:0]  sel_data;
   logic           out_ready;
   logic           accept;

   rr_pick #(
      .N  (N_IN),
      .IW (IDW)
   ) u_pick (
      .req        (s_tvalid),
      .last_grant (last_grant),
      .grant      (pick_idx),
      .any_req    (any_req)
   );

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (grant_id == IDW'(i)) begin
            sel_valid = s_tvalid[i];
            sel_last  = s_tlast[i];
            sel_data  = s_tdata[i*DW +: DW];
         end
      end
   end

   // The output slot can take a beat when empty or when its current beat leaves this cycle.
   assign out_ready = !m_tvalid || m_tready;
   assign accept    = (state == LOCK) && sel_valid && out_ready;
   assign busy      = (state == LOCK);

   always_comb begin
      s_tready = '0;
      for (int i = 0; i < N_IN; i++) begin
         s_tready[i] = (state == LOCK) && (grant_id == IDW'(i)) && out_ready;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (any_req) state_nxt = LOCK;
         LOCK: if (accept && sel_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Starting from the highest index makes input 0 the first winner after reset.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         grant_id   <= '0;
         last_grant <= IDW'(N_IN - 1);
      end else begin
         if (state == IDLE && any_req) begin
            grant_id <= pick_idx;
         end
         if (accept && sel_last) begin
            last_grant <= grant_id;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
      end else if (accept) begin
         m_tdata  <= sel_data;
         m_tlast  <= sel_last;
         m_tvalid <= 1'b1;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

endmodule
